// File: rtl/axil_master_rr_arbiter_if.sv
// Bundle of client request/response signals and the m01 AXI4-Lite master channels.
// The master modport is the arbiter's view; slave is the environment's view.
interface axil_master_rr_arbiter_if #(
    parameter int unsigned num_clients_p = 2,
    parameter int unsigned addr_width_p  = 32,
    parameter int unsigned data_width_p  = 32
);
    localparam int unsigned N = num_clients_p;
    localparam int unsigned A = addr_width_p;
    localparam int unsigned D = data_width_p;

    logic [N-1:0]       req_v_i;
    logic [N-1:0]       req_ready_o;
    logic [N-1:0]       req_we_i;
    logic [N*A-1:0]     req_addr_i;
    logic [N*D-1:0]     req_data_i;
    logic [N*D/8-1:0]   req_wstrb_i;
    logic [N-1:0]       resp_v_o;
    logic [N-1:0]       resp_ready_i;
    logic [D-1:0]       resp_data_o;
    logic               resp_err_o;

    logic [A-1:0]       m01_axi_awaddr;
    logic [2:0]         m01_axi_awprot;
    logic               m01_axi_awvalid;
    logic               m01_axi_awready;
    logic [D-1:0]       m01_axi_wdata;
    logic [D/8-1:0]     m01_axi_wstrb;
    logic               m01_axi_wvalid;
    logic               m01_axi_wready;
    logic [1:0]         m01_axi_bresp;
    logic               m01_axi_bvalid;
    logic               m01_axi_bready;
    logic [A-1:0]       m01_axi_araddr;
    logic [2:0]         m01_axi_arprot;
    logic               m01_axi_arvalid;
    logic               m01_axi_arready;
    logic [D-1:0]       m01_axi_rdata;
    logic [1:0]         m01_axi_rresp;
    logic               m01_axi_rvalid;
    logic               m01_axi_rready;

    modport master (
        input  req_v_i, req_we_i, req_addr_i, req_data_i, req_wstrb_i, resp_ready_i,
        output req_ready_o, resp_v_o, resp_data_o, resp_err_o,
        output m01_axi_awaddr, m01_axi_awprot, m01_axi_awvalid,
        input  m01_axi_awready,
        output m01_axi_wdata, m01_axi_wstrb, m01_axi_wvalid,
        input  m01_axi_wready,
        input  m01_axi_bresp, m01_axi_bvalid,
        output m01_axi_bready,
        output m01_axi_araddr, m01_axi_arprot, m01_axi_arvalid,
        input  m01_axi_arready,
        input  m01_axi_rdata, m01_axi_rresp, m01_axi_rvalid,
        output m01_axi_rready
    );

    modport slave (
        output req_v_i, req_we_i, req_addr_i, req_data_i, req_wstrb_i, resp_ready_i,
        input  req_ready_o, resp_v_o, resp_data_o, resp_err_o,
        input  m01_axi_awaddr, m01_axi_awprot, m01_axi_awvalid,
        output m01_axi_awready,
        input  m01_axi_wdata, m01_axi_wstrb, m01_axi_wvalid,
        output m01_axi_wready,
        output m01_axi_bresp, m01_axi_bvalid,
        input  m01_axi_bready,
        input  m01_axi_araddr, m01_axi_arprot, m01_axi_arvalid,
        output m01_axi_arready,
        output m01_axi_rdata, m01_axi_rresp, m01_axi_rvalid,
        input  m01_axi_rready
    );
endinterface

// File: rtl/axil_master_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among several requesters.
// One transaction in flight; the response is returned to the granted client before re-arbitration.
module axil_master_rr_arbiter #(
    parameter int unsigned num_clients_p = 2,
    parameter int unsigned addr_width_p  = 32,
    parameter int unsigned data_width_p  = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    axil_master_rr_arbiter_if.master bus
);
    localparam int unsigned N    = num_clients_p;
    localparam int unsigned A    = addr_width_p;
    localparam int unsigned D    = data_width_p;
    localparam int unsigned S    = D / 8;
    localparam int unsigned IdxW = $clog2(num_clients_p);
    localparam int unsigned SumW = IdxW + 1;

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] S_WR_RESP      = 3'd2;
    localparam logic [2:0] S_RD_ADDR      = 3'd3;
    localparam logic [2:0] S_RD_DATA      = 3'd4;
    localparam logic [2:0] S_RESP         = 3'd5;

    logic [2:0]      r_state, w_state_d;
    logic [IdxW-1:0] r_ptr, w_ptr_d;
    logic [IdxW-1:0] r_grant, w_grant_d;
    logic [A-1:0]    r_addr, w_addr_d;
    logic [D-1:0]    r_wdata, w_wdata_d;
    logic [S-1:0]    r_wstrb, w_wstrb_d;
    logic [D-1:0]    r_resp_data, w_resp_data_d;
    logic            r_resp_err, w_resp_err_d;
    logic            r_aw_done, w_aw_done_d;
    logic            r_w_done, w_w_done_d;

    logic            w_found;
    logic [IdxW-1:0] w_winner;
    logic [SumW-1:0] w_sum;
    logic [N-1:0]    w_win_onehot;
    logic [N-1:0]    w_grant_onehot;
    logic            w_awvalid;
    logic            w_wvalid;
    logic            w_unused_resp;

    // Search upward from the pointer with wrap-around; the pointer never exceeds N-1.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + SumW'(k);
            if (w_sum >= SumW'(N)) begin
                w_sum = w_sum - SumW'(N);
            end
            if (!w_found && bus.req_v_i[w_sum[IdxW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IdxW-1:0];
            end
        end
    end

    assign w_win_onehot   = {{(N-1){1'b0}}, 1'b1} << w_winner;
    assign w_grant_onehot = {{(N-1){1'b0}}, 1'b1} << r_grant;

    assign w_awvalid = (r_state == S_WR_ADDR_DATA) && !r_aw_done;
    assign w_wvalid  = (r_state == S_WR_ADDR_DATA) && !r_w_done;

    always_comb begin
        w_state_d     = r_state;
        w_ptr_d       = r_ptr;
        w_grant_d     = r_grant;
        w_addr_d      = r_addr;
        w_wdata_d     = r_wdata;
        w_wstrb_d     = r_wstrb;
        w_resp_data_d = r_resp_data;
        w_resp_err_d  = r_resp_err;
        w_aw_done_d   = r_aw_done;
        w_w_done_d    = r_w_done;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_d   = w_winner;
                    w_ptr_d     = (w_winner == IdxW'(N - 1)) ? '0 : w_winner + 1'b1;
                    w_addr_d    = bus.req_addr_i[w_winner*A +: A];
                    w_wdata_d   = bus.req_data_i[w_winner*D +: D];
                    w_wstrb_d   = bus.req_wstrb_i[w_winner*S +: S];
                    w_aw_done_d = 1'b0;
                    w_w_done_d  = 1'b0;
                    w_state_d   = bus.req_we_i[w_winner] ? S_WR_ADDR_DATA : S_RD_ADDR;
                end
            end
            S_WR_ADDR_DATA: begin
                w_aw_done_d = r_aw_done | (w_awvalid & bus.m01_axi_awready);
                w_w_done_d  = r_w_done | (w_wvalid & bus.m01_axi_wready);
                if (w_aw_done_d && w_w_done_d) begin
                    w_state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bus.m01_axi_bvalid) begin
                    w_resp_err_d  = bus.m01_axi_bresp[1];
                    w_resp_data_d = '0;
                    w_state_d     = S_RESP;
                end
            end
            S_RD_ADDR: begin
                if (bus.m01_axi_arready) begin
                    w_state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (bus.m01_axi_rvalid) begin
                    w_resp_data_d = bus.m01_axi_rdata;
                    w_resp_err_d  = bus.m01_axi_rresp[1];
                    w_state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready_i[r_grant]) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_grant     <= w_grant_d;
            r_addr      <= w_addr_d;
            r_wdata     <= w_wdata_d;
            r_wstrb     <= w_wstrb_d;
            r_resp_data <= w_resp_data_d;
            r_resp_err  <= w_resp_err_d;
            r_aw_done   <= w_aw_done_d;
            r_w_done    <= w_w_done_d;
        end
    end

    // Gated by aresetn so a request held through reset is not acknowledged.
    assign bus.req_ready_o = (aresetn && r_state == S_IDLE && w_found) ? w_win_onehot : '0;
    assign bus.resp_v_o    = (r_state == S_RESP) ? w_grant_onehot : '0;
    assign bus.resp_data_o = r_resp_data;
    assign bus.resp_err_o  = r_resp_err;

    assign bus.m01_axi_awaddr  = r_addr;
    assign bus.m01_axi_awprot  = 3'b000;
    assign bus.m01_axi_awvalid = w_awvalid;
    assign bus.m01_axi_wdata   = r_wdata;
    assign bus.m01_axi_wstrb   = r_wstrb;
    assign bus.m01_axi_wvalid  = w_wvalid;
    assign bus.m01_axi_bready  = (r_state == S_WR_RESP);
    assign bus.m01_axi_araddr  = r_addr;
    assign bus.m01_axi_arprot  = 3'b000;
    assign bus.m01_axi_arvalid = (r_state == S_RD_ADDR);
    assign bus.m01_axi_rready  = (r_state == S_RD_DATA);

    assign w_unused_resp = ^{bus.m01_axi_bresp[0], bus.m01_axi_rresp[0]};
endmodule

// File: tb/tb_axil_master_rr_arbiter.sv
// Directed bench for axil_master_rr_arbiter with two clients and a small AXI4-Lite slave model.
module tb_axil_master_rr_arbiter;
    logic aclk;
    logic aresetn;

    int n_total = 0;
    int n_bad   = 0;

    // Slave response knobs, sampled by the slave model at the falling edge.
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [1:0]  s_bresp;
    bit          s_r_stall;

    axil_master_rr_arbiter_if #(
        .num_clients_p(2),
        .addr_width_p (32),
        .data_width_p (32)
    ) bus ();

    axil_master_rr_arbiter #(
        .num_clients_p(2),
        .addr_width_p (32),
        .data_width_p (32)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Leaves the caller at the falling edge where a response is visible (or budget is spent).
    task automatic wait_resp(input string tag, input logic [1:0] who);
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            if (bus.resp_v_o != 2'b00) break;
            step();
        end
        chk(tag, bus.resp_v_o, who);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready_o, 2'b00);
        chk({tag, "_resp_v"}, bus.resp_v_o, 2'b00);
        chk({tag, "_awvalid"}, bus.m01_axi_awvalid, 1'b0);
        chk({tag, "_wvalid"}, bus.m01_axi_wvalid, 1'b0);
        chk({tag, "_arvalid"}, bus.m01_axi_arvalid, 1'b0);
        chk({tag, "_bready"}, bus.m01_axi_bready, 1'b0);
        chk({tag, "_rready"}, bus.m01_axi_rready, 1'b0);
        chk({tag, "_resp_data"}, bus.resp_data_o, 32'h0);
        chk({tag, "_resp_err"}, bus.resp_err_o, 1'b0);
    endtask

    // AXI4-Lite slave: responds one cycle after the address/data handshakes it observed.
    initial begin : slave_model
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, stall;
        logic [31:0] nd;
        logic [1:0]  nr, nb;
        aw_got = 0; w_got = 0; stall = 0; nd = '0; nr = '0; nb = '0;
        bus.m01_axi_bvalid = 1'b0;
        bus.m01_axi_bresp  = 2'b00;
        bus.m01_axi_rvalid = 1'b0;
        bus.m01_axi_rdata  = '0;
        bus.m01_axi_rresp  = 2'b00;
        forever begin
            @(negedge aclk);
            aw_hs = bus.m01_axi_awvalid && bus.m01_axi_awready;
            w_hs  = bus.m01_axi_wvalid && bus.m01_axi_wready;
            b_hs  = bus.m01_axi_bvalid && bus.m01_axi_bready;
            ar_hs = bus.m01_axi_arvalid && bus.m01_axi_arready;
            r_hs  = bus.m01_axi_rvalid && bus.m01_axi_rready;
            nb    = s_bresp;
            if (ar_hs) begin
                stall = s_r_stall;
                nd    = s_rdata;
                nr    = s_rresp;
            end
            @(posedge aclk);
            #1;
            if (b_hs) bus.m01_axi_bvalid = 1'b0;
            if (r_hs) bus.m01_axi_rvalid = 1'b0;
            if (aw_hs) aw_got = 1;
            if (w_hs) w_got = 1;
            if (aw_got && w_got) begin
                bus.m01_axi_bvalid = 1'b1;
                bus.m01_axi_bresp  = nb;
                aw_got = 0;
                w_got  = 0;
            end
            if (ar_hs && !stall) begin
                bus.m01_axi_rvalid = 1'b1;
                bus.m01_axi_rdata  = nd;
                bus.m01_axi_rresp  = nr;
            end
        end
    end

    initial begin : stimulus
        bit          got;
        bit          saw_resp;
        logic [1:0]  exp_grant;

        aresetn              = 1'b0;
        bus.req_v_i          = 2'b01;
        bus.req_we_i         = 2'b00;
        bus.req_addr_i       = '0;
        bus.req_data_i       = '0;
        bus.req_wstrb_i      = '0;
        bus.resp_ready_i     = 2'b11;
        bus.m01_axi_awready  = 1'b1;
        bus.m01_axi_wready   = 1'b1;
        bus.m01_axi_arready  = 1'b1;
        s_rdata   = 32'h0;
        s_rresp   = 2'b00;
        s_bresp   = 2'b00;
        s_r_stall = 0;

        @(negedge aclk);
        chk_reset_outputs("rst0");
        step();
        bus.req_v_i = 2'b00;
        aresetn     = 1'b1;
        step();

        // Single write from client 0.
        bus.req_we_i          = 2'b01;
        bus.req_addr_i[31:0]  = 32'h1000_0010;
        bus.req_data_i[31:0]  = 32'hDEAD_BEEF;
        bus.req_wstrb_i[3:0]  = 4'hF;
        bus.req_v_i           = 2'b01;
        @(negedge aclk);
        chk("wr_grant", bus.req_ready_o, 2'b01);
        chk("wr_c0_awvalid", bus.m01_axi_awvalid, 1'b0);
        step();
        bus.req_v_i = 2'b00;
        @(negedge aclk);
        chk("wr_c1_awvalid", bus.m01_axi_awvalid, 1'b1);
        chk("wr_c1_wvalid", bus.m01_axi_wvalid, 1'b1);
        chk("wr_awaddr", bus.m01_axi_awaddr, 32'h1000_0010);
        chk("wr_wdata", bus.m01_axi_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", bus.m01_axi_wstrb, 4'hF);
        chk("wr_awprot", bus.m01_axi_awprot, 3'b000);
        chk("wr_c1_req_ready", bus.req_ready_o, 2'b00);
        step();
        @(negedge aclk);
        chk("wr_c2_bready", bus.m01_axi_bready, 1'b1);
        chk("wr_c2_awvalid", bus.m01_axi_awvalid, 1'b0);
        chk("wr_c2_resp_v", bus.resp_v_o, 2'b00);
        step();
        @(negedge aclk);
        chk("wr_c3_resp_v", bus.resp_v_o, 2'b01);
        chk("wr_resp_err", bus.resp_err_o, 1'b0);
        chk("wr_resp_data", bus.resp_data_o, 32'h0);
        step();
        @(negedge aclk);
        chk("wr_c4_resp_v", bus.resp_v_o, 2'b00);

        // Single read from client 1 with SLVERR.
        step();
        s_rdata                = 32'h1234_5678;
        s_rresp                = 2'b10;
        bus.req_we_i           = 2'b00;
        bus.req_addr_i[63:32]  = 32'h1000_0020;
        bus.req_v_i            = 2'b10;
        @(negedge aclk);
        chk("rd_grant", bus.req_ready_o, 2'b10);
        step();
        bus.req_v_i = 2'b00;
        @(negedge aclk);
        chk("rd_c1_arvalid", bus.m01_axi_arvalid, 1'b1);
        chk("rd_araddr", bus.m01_axi_araddr, 32'h1000_0020);
        step();
        @(negedge aclk);
        chk("rd_c2_rready", bus.m01_axi_rready, 1'b1);
        chk("rd_c2_arvalid", bus.m01_axi_arvalid, 1'b0);
        step();
        @(negedge aclk);
        chk("rd_c3_resp_v", bus.resp_v_o, 2'b10);
        chk("rd_resp_data", bus.resp_data_o, 32'h1234_5678);
        chk("rd_resp_err", bus.resp_err_o, 1'b1);
        step();

        // Contention: both clients hold read requests across six grants.
        s_rdata               = 32'h0000_5555;
        s_rresp               = 2'b00;
        bus.req_addr_i[31:0]  = 32'h1000_0100;
        bus.req_addr_i[63:32] = 32'h1000_0200;
        bus.req_v_i           = 2'b11;
        saw_resp              = 0;
        for (int t = 0; t < 6; t++) begin
            exp_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
            got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge aclk);
                if (bus.resp_v_o != 2'b00) saw_resp = 1;
                if (bus.req_ready_o != 2'b00) begin
                    chk("cont_grant", bus.req_ready_o, exp_grant);
                    if (t > 0) chk("cont_resp_between", saw_resp, 1'b1);
                    saw_resp = 0;
                    got = 1;
                end
                step();
            end
            if (!got) chk("cont_grant_timeout", 1'b0, 1'b1);
        end
        bus.req_v_i = 2'b00;
        wait_resp("cont_last_resp", 2'b10);
        chk("cont_last_data", bus.resp_data_o, 32'h0000_5555);
        step();

        // Channel skew: awready low for three cycles, wready immediate.
        bus.m01_axi_awready  = 1'b0;
        s_bresp              = 2'b00;
        bus.req_we_i         = 2'b01;
        bus.req_addr_i[31:0] = 32'h2000_0004;
        bus.req_data_i[31:0] = 32'hA5A5_5A5A;
        bus.req_wstrb_i[3:0] = 4'h3;
        bus.req_v_i          = 2'b01;
        @(negedge aclk);
        chk("skew_grant", bus.req_ready_o, 2'b01);
        step();
        bus.req_v_i = 2'b00;
        @(negedge aclk);
        chk("skew_c1_awvalid", bus.m01_axi_awvalid, 1'b1);
        chk("skew_c1_wvalid", bus.m01_axi_wvalid, 1'b1);
        step();
        @(negedge aclk);
        chk("skew_c2_wvalid", bus.m01_axi_wvalid, 1'b0);
        chk("skew_c2_awvalid", bus.m01_axi_awvalid, 1'b1);
        chk("skew_c2_bready", bus.m01_axi_bready, 1'b0);
        step();
        @(negedge aclk);
        chk("skew_c3_awvalid", bus.m01_axi_awvalid, 1'b1);
        chk("skew_c3_awaddr", bus.m01_axi_awaddr, 32'h2000_0004);
        chk("skew_c3_bready", bus.m01_axi_bready, 1'b0);
        step();
        bus.m01_axi_awready = 1'b1;
        @(negedge aclk);
        chk("skew_c4_awvalid", bus.m01_axi_awvalid, 1'b1);
        chk("skew_c4_bready", bus.m01_axi_bready, 1'b0);
        step();
        @(negedge aclk);
        chk("skew_c5_bready", bus.m01_axi_bready, 1'b1);
        chk("skew_c5_awvalid", bus.m01_axi_awvalid, 1'b0);
        step();
        @(negedge aclk);
        chk("skew_c6_resp_v", bus.resp_v_o, 2'b01);
        chk("skew_resp_data", bus.resp_data_o, 32'h0);
        chk("skew_resp_err", bus.resp_err_o, 1'b0);
        step();

        // Response backpressure on client 0, with client 1 queued behind it.
        s_rdata              = 32'hCAFE_F00D;
        s_rresp              = 2'b11;
        bus.resp_ready_i     = 2'b10;
        bus.req_we_i         = 2'b00;
        bus.req_addr_i[31:0] = 32'h3000_0000;
        bus.req_v_i          = 2'b01;
        @(negedge aclk);
        chk("bp_grant", bus.req_ready_o, 2'b01);
        step();
        bus.req_addr_i[63:32] = 32'h3000_0100;
        bus.req_v_i           = 2'b10;
        @(negedge aclk);
        chk("bp_c1_req_ready", bus.req_ready_o, 2'b00);
        step();
        @(negedge aclk);
        chk("bp_c2_rready", bus.m01_axi_rready, 1'b1);
        step();
        s_rdata = 32'h0BAD_0001;
        s_rresp = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("bp_hold_resp_v", bus.resp_v_o, 2'b01);
            chk("bp_hold_data", bus.resp_data_o, 32'hCAFE_F00D);
            chk("bp_hold_err", bus.resp_err_o, 1'b1);
            chk("bp_hold_req_ready", bus.req_ready_o, 2'b00);
            step();
        end
        bus.resp_ready_i = 2'b11;
        @(negedge aclk);
        chk("bp_accept_resp_v", bus.resp_v_o, 2'b01);
        step();
        @(negedge aclk);
        chk("bp_next_grant", bus.req_ready_o, 2'b10);
        step();
        bus.req_v_i = 2'b00;
        wait_resp("bp_c1_resp", 2'b10);
        chk("bp_c1_data", bus.resp_data_o, 32'h0BAD_0001);
        chk("bp_c1_err", bus.resp_err_o, 1'b1);
        step();

        // Reset while client 0's read is stuck in the data phase.
        s_r_stall            = 1;
        bus.req_addr_i[31:0] = 32'h4000_0000;
        bus.req_v_i          = 2'b01;
        @(negedge aclk);
        chk("mrst_grant", bus.req_ready_o, 2'b01);
        step();
        bus.req_v_i = 2'b00;
        @(negedge aclk);
        chk("mrst_arvalid", bus.m01_axi_arvalid, 1'b1);
        step();
        @(negedge aclk);
        chk("mrst_c2_rready", bus.m01_axi_rready, 1'b1);
        step();
        @(negedge aclk);
        chk("mrst_c3_rready", bus.m01_axi_rready, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("mrst");
        bus.req_v_i = 2'b11;
        #1;
        chk("mrst_req_ready_in_reset", bus.req_ready_o, 2'b00);
        s_r_stall = 0;
        step();
        step();
        aresetn  = 1'b1;
        s_rdata  = 32'h600D_0000;
        s_rresp  = 2'b00;
        @(negedge aclk);
        chk("mrst_first_priority", bus.req_ready_o, 2'b01);
        step();
        bus.req_v_i = 2'b00;
        wait_resp("mrst_post_resp", 2'b01);
        chk("mrst_post_data", bus.resp_data_o, 32'h600D_0000);
        chk("mrst_post_err", bus.resp_err_o, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
